// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and the byte-consumer state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WAIT
    } state_t;

endpackage

// File: rtl/ps2_scan_tracker.sv
// Pops scan-code bytes from the PS/2 receiver FIFO, strips E0/F0 prefixes,
// tracks the held key, suppresses typematic repeats and counts presses.
module ps2_scan_tracker
    import ps2_pkg::*;
#(
    parameter int COUNT_W       = 8,
    parameter bit IGNORE_REPEAT = 1'b1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [7:0]         in_data,
    input  logic               in_ready,
    output logic               nextdata_n,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_valid,
    output logic [COUNT_W-1:0] press_count,
    output logic               make_pulse,
    output logic               break_pulse
);

    state_t             state, state_nx;
    logic               ext_pend, ext_pend_nx;
    logic               brk_pend, brk_pend_nx;
    logic [7:0]         key_code_nx;
    logic               key_ext_nx;
    logic               key_valid_nx;
    logic [COUNT_W-1:0] press_count_nx;
    logic               make_nx;
    logic               break_nx;
    logic               same_key;

    // A byte matches the held key only if its extended flag matches too.
    assign same_key = key_valid && (key_code == in_data) && (key_ext == ext_pend);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nx       = state;
        ext_pend_nx    = ext_pend;
        brk_pend_nx    = brk_pend;
        key_code_nx    = key_code;
        key_ext_nx     = key_ext;
        key_valid_nx   = key_valid;
        press_count_nx = press_count;
        make_nx        = 1'b0;
        break_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (in_ready) begin
                    state_nx = POP;
                    if (in_data == PS2_EXT) begin
                        ext_pend_nx = 1'b1;
                    end else if (in_data == PS2_BRK) begin
                        brk_pend_nx = 1'b1;
                    end else if (in_data == PS2_ERR_LO || in_data == PS2_ERR_HI) begin
                        ext_pend_nx = 1'b0;
                        brk_pend_nx = 1'b0;
                    end else if (brk_pend) begin
                        // A break of a key other than the held one still strobes.
                        break_nx    = 1'b1;
                        ext_pend_nx = 1'b0;
                        brk_pend_nx = 1'b0;
                        if (same_key) begin
                            key_valid_nx = 1'b0;
                        end
                    end else begin
                        ext_pend_nx = 1'b0;
                        if (!(IGNORE_REPEAT && same_key)) begin
                            key_code_nx    = in_data;
                            key_ext_nx     = ext_pend;
                            key_valid_nx   = 1'b1;
                            press_count_nx = press_count + COUNT_W'(1);
                            make_nx        = 1'b1;
                        end
                    end
                end
            end
            POP:     state_nx = WAIT;
            WAIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: every register here is cleared by the async reset; there is no memory array to leave unreset.
        if (!clrn) begin
            state       <= IDLE;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_valid   <= 1'b0;
            press_count <= '0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
        end else begin
            state       <= state_nx;
            ext_pend    <= ext_pend_nx;
            brk_pend    <= brk_pend_nx;
            key_code    <= key_code_nx;
            key_ext     <= key_ext_nx;
            key_valid   <= key_valid_nx;
            press_count <= press_count_nx;
            make_pulse  <= make_nx;
            break_pulse <= break_nx;
        end
    end

    // Pop is a pure decode of the state register, so it is low for POP only.
    assign nextdata_n = (state != POP);

endmodule
